fft_frame_feeder: RTL and testbench

Source-side companion to the 32-point `FFT` core. Accepts complex samples one at a time from an upstream valid/ready stream, assembles them into complete frames in a ping-pong buffer, and drives each frame to the FFT as an unbroken `in_valid` burst of `FFT_size` consecutive cycles. The FFT's own `out_valid` is fed back as a credit return, so a new burst never starts while the FFT is still busy with earlier frames.

---
 rtl/fft_frame_feeder_if.sv | 21 ++
 rtl/fft_frame_feeder.sv | 128 ++++++++++++
 tb/tb_fft_frame_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
// rtl/fft_frame_feeder_if.sv - upstream sample stream and FFT-side burst signals of the frame feeder
interface fft_frame_feeder_if #(parameter int IN_width = 12);
  logic                       s_valid;
  logic                       s_ready;
  logic signed [IN_width-1:0] s_r;
  logic signed [IN_width-1:0] s_i;
  logic                       in_valid;
  logic signed [IN_width-1:0] din_r;
  logic signed [IN_width-1:0] din_i;
  logic                       out_valid;

  // master is the feeder; slave is the source plus FFT core around it
  modport master (
    input  s_valid, s_r, s_i, out_valid,
    output s_ready, in_valid, din_r, din_i
  );
  modport slave (
    output s_valid, s_r, s_i, out_valid,
    input  s_ready, in_valid, din_r, din_i
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ping-pong frame buffer feeding an FFT with contiguous, credit-limited bursts
module fft_frame_feeder #(
  parameter int FFT_size     = 32,
  parameter int IN_width     = 12,
  parameter int MIN_GAP      = 1,
  parameter int MAX_INFLIGHT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_feeder_if.master bus,
  output logic               busy,
  output logic               err
);
  localparam int IDX_W = $clog2(FFT_size);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int CR_W  = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_size - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  logic [2*IN_width-1:0] mem [2][FFT_size];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_idx_nx;
  logic [IDX_W-1:0] ov_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nx;
  logic [CR_W-1:0]  credit;
  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             start_ok;
  logic             ret;
  logic             load;
  logic             start;
  logic             finish;

  assign bus.s_ready = rst_n & ~full[wr_sel];
  assign accept      = bus.s_valid & bus.s_ready;
  assign start_ok    = full[rd_sel] & (credit != '0);
  // one credit comes back per FFT_size result cycles
  assign ret         = bus.out_valid & (ov_cnt == LAST_IDX);
  assign busy        = (full != 2'b00) | (state != IDLE) | (credit != CR_MAX);

  always_comb begin
    state_nx  = state;
    rd_idx_nx = rd_idx;
    gap_nx    = gap_cnt;
    load      = 1'b0;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: start = start_ok;
      BURST: begin
        load      = 1'b1;
        rd_idx_nx = rd_idx + 1'b1;
        if (rd_idx == LAST_IDX) begin
          finish   = 1'b1;
          state_nx = GAP;
          gap_nx   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt != '0) gap_nx = gap_cnt - 1'b1;
        else if (start_ok) start = 1'b1;
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // a start loads sample 0 on this edge, so the burst continues from index 1
    if (start) begin
      load      = 1'b1;
      state_nx  = BURST;
      rd_idx_nx = IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_sel][wr_idx] <= {bus.s_r, bus.s_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      gap_cnt   <= '0;
      ov_cnt    <= '0;
      credit    <= CR_MAX;
      err       <= 1'b0;
      bus.in_valid <= 1'b0;
      bus.din_r    <= '0;
      bus.din_i    <= '0;
    end else begin
      state   <= state_nx;
      rd_idx  <= rd_idx_nx;
      gap_cnt <= gap_nx;
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LAST_IDX) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (finish) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      bus.in_valid <= load;
      if (load) {bus.din_r, bus.din_i} <= mem[rd_sel][rd_idx];
      if (bus.out_valid) ov_cnt <= ov_cnt + 1'b1;
      if (start && !ret) begin
        credit <= credit - 1'b1;
      end else if (ret && !start) begin
        if (credit == CR_MAX) err <= 1'b1;
        else credit <= credit + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - randomized scoreboard bench for the FFT frame feeder
module tb_fft_frame_feeder;
  localparam int N    = 32;
  localparam int W    = 12;
  localparam int GAP1 = 1;
  localparam int INF1 = 1;
  localparam int GAP3 = 3;
  localparam int INF3 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err, busy3, err3;
  always #5 clk = ~clk;

  fft_frame_feeder_if #(.IN_width(W)) bus ();
  fft_frame_feeder_if #(.IN_width(W)) bus3 ();

  fft_frame_feeder #(.FFT_size(N), .IN_width(W), .MIN_GAP(GAP1), .MAX_INFLIGHT(INF1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err));
  fft_frame_feeder #(.FFT_size(N), .IN_width(W), .MIN_GAP(GAP3), .MAX_INFLIGHT(INF3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3), .err(err3));

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic signed [W-1:0] cap_r [N];
  int widx, credit_m, ovc, owed, run, gap, last_gap, cyc_n, frame_done_cyc;
  int start_cyc, end_cyc, acc_cnt, bursts;
  bit err_m, prev_iv, ov_prev, had_burst, auto_ov, rand_data, last_srdy;

  task automatic model_clear();
    exp_q.delete();
    widx = 0; credit_m = INF1; ovc = 0; owed = 0; run = 0; gap = 1000; last_gap = 0;
    frame_done_cyc = -1; start_cyc = -1; end_cyc = -1; acc_cnt = 0; bursts = 0;
    err_m = 0; prev_iv = 0; ov_prev = 0; had_burst = 0; auto_ov = 0; rand_data = 0;
  endtask

  task automatic idle_inputs();
    bus.s_valid = 0; bus.s_r = '0; bus.s_i = '0; bus.out_valid = 0;
    bus3.s_valid = 0; bus3.s_r = '0; bus3.s_i = '0; bus3.out_valid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // one clock of stimulus on the main DUT, with the scoreboard applied to what the last edge produced
  task automatic cyc(input bit sv, input bit ov_man);
    logic [2*W-1:0] e;
    logic signed [W-1:0] nr, ni;
    bit ov;
    @(negedge clk);
    cyc_n++;
    if (bus.in_valid && !prev_iv) begin
      total++;
      if (credit_m == 0) begin
        bad++; $display("FAIL burst_credit: burst started with model credit %0d, need >0", credit_m);
      end else credit_m--;
      if (had_burst) begin
        total++;
        if (gap < GAP1) begin bad++; $display("FAIL gap_min: gap %0d, need >=%0d", gap, GAP1); end
      end
      last_gap = gap; had_burst = 1; bursts++; start_cyc = cyc_n; run = 0;
      if (auto_ov) owed += N;
    end
    if (bus.in_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL burst_data: got %h, no sample expected", {bus.din_r, bus.din_i});
      end else begin
        e = exp_q.pop_front();
        if ({bus.din_r, bus.din_i} !== e) begin
          bad++; $display("FAIL burst_data: got %h, need %h", {bus.din_r, bus.din_i}, e);
        end
      end
      if (run < N) cap_r[run] = bus.din_r;
      run++;
    end else if (prev_iv) begin
      total++;
      if (run != N) begin bad++; $display("FAIL burst_len: got %0d, need %0d", run, N); end
      gap = 1; end_cyc = cyc_n;
    end else gap++;
    if (ov_prev) begin
      ovc++;
      if (ovc == N) begin
        ovc = 0;
        if (credit_m == INF1) err_m = 1; else credit_m++;
      end
    end
    total++;
    if (err !== err_m) begin bad++; $display("FAIL err_flag: got %b, need %b", err, err_m); end
    prev_iv = bus.in_valid;
    last_srdy = bus.s_ready;
    ov = ov_man;
    if (auto_ov && owed > 0 && (!rand_data || $urandom_range(0, 1) == 1)) begin
      ov = 1; owed--;
    end
    if (rand_data) begin
      nr = W'($urandom);
      if (widx == 5) nr = -12'sd2048;
      if (widx == 31) nr = 12'sd2047;
    end else nr = W'(widx);
    ni = W'($urandom);
    if (sv && last_srdy) begin
      exp_q.push_back({nr, ni});
      acc_cnt++; widx++;
      if (widx == N) begin widx = 0; frame_done_cyc = cyc_n; end
    end
    bus.s_valid = sv; bus.s_r = nr; bus.s_i = ni; bus.out_valid = ov; ov_prev = ov;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    model_clear();
    #1;
    total += 6;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b, need 0", bus.s_ready); end
    if (bus.in_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid: got %b, need 0", bus.in_valid); end
    if (bus.din_r !== '0) begin bad++; $display("FAIL rst_din_r: got %h, need 0", bus.din_r); end
    if (bus.din_i !== '0) begin bad++; $display("FAIL rst_din_i: got %h, need 0", bus.din_i); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, need 0", busy); end
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, need 0", err); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready: got %b, need 1", bus.s_ready); end
  endtask

  task automatic test_first_frame();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      cyc(1, 0);
      total++;
      if (last_srdy !== 1'b1) begin bad++; $display("FAIL fill_s_ready: got %b, need 1", last_srdy); end
    end
    cyc(0, 0);
    total++;
    if (bus.in_valid !== 1'b0) begin bad++; $display("FAIL early_start: in_valid %b, need 0", bus.in_valid); end
    cyc(0, 0);
    total += 3;
    if (bus.in_valid !== 1'b1) begin bad++; $display("FAIL first_latency: in_valid %b, need 1", bus.in_valid); end
    if (start_cyc != frame_done_cyc + 2) begin
      bad++; $display("FAIL first_start_cyc: got %0d, need %0d", start_cyc, frame_done_cyc + 2);
    end
    if (bus.din_r !== 12'sd0) begin bad++; $display("FAIL first_din: got %0d, need 0", bus.din_r); end
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0);
      total++;
      if (last_srdy !== 1'b1) begin bad++; $display("FAIL burst_s_ready: got %b, need 1", last_srdy); end
    end
    total += 2;
    if (bursts != 1) begin bad++; $display("FAIL first_bursts: got %0d, need 1", bursts); end
    if (cap_r[31] !== 12'sd31) begin bad++; $display("FAIL first_last: got %0d, need 31", cap_r[31]); end
  endtask

  task automatic test_credit();
    int pulse_cyc;
    apply_reset();
    for (int c = 0; c < 140; c++) cyc(1, 0);
    total += 4;
    if (acc_cnt != 3 * N) begin bad++; $display("FAIL credit_accepts: got %0d, need %0d", acc_cnt, 3 * N); end
    if (bursts != 1) begin bad++; $display("FAIL credit_bursts: got %0d, need 1", bursts); end
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL credit_s_ready: got %b, need 0", bus.s_ready); end
    if (busy !== 1'b1) begin bad++; $display("FAIL credit_busy: got %b, need 1", busy); end
    for (int i = 0; i < N; i++) cyc(0, 1);
    pulse_cyc = cyc_n;
    cyc(0, 0);
    total++;
    if (bus.in_valid !== 1'b0) begin bad++; $display("FAIL return_early: in_valid %b, need 0", bus.in_valid); end
    cyc(0, 0);
    total += 2;
    if (bus.in_valid !== 1'b1) begin bad++; $display("FAIL return_start: in_valid %b, need 1", bus.in_valid); end
    if (start_cyc != pulse_cyc + 2) begin
      bad++; $display("FAIL return_cyc: got %0d, need %0d", start_cyc, pulse_cyc + 2);
    end
    for (int i = 0; i < 40; i++) cyc(0, 0);
    total += 2;
    if (bursts != 2) begin bad++; $display("FAIL return_bursts: got %0d, need 2", bursts); end
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL freed_s_ready: got %b, need 1", bus.s_ready); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    auto_ov = 1;
    for (int c = 0; c < 400; c++) begin
      cyc(1, 0);
      if (start_cyc == cyc_n && bursts >= 2) begin
        total++;
        if (last_gap != GAP1) begin bad++; $display("FAIL b2b_gap: got %0d, need %0d", last_gap, GAP1); end
      end
    end
    total++;
    if (bursts < 10) begin bad++; $display("FAIL b2b_bursts: got %0d, need >=10", bursts); end
  endtask

  task automatic test_random();
    apply_reset();
    auto_ov = 1; rand_data = 1;
    for (int c = 0; c < 800; c++) begin
      cyc(bit'($urandom_range(0, 1)), 0);
      if (end_cyc == cyc_n) begin
        total += 2;
        if (cap_r[5] !== -12'sd2048) begin bad++; $display("FAIL rand_idx5: got %0d, need -2048", cap_r[5]); end
        if (cap_r[31] !== 12'sd2047) begin bad++; $display("FAIL rand_idx31: got %0d, need 2047", cap_r[31]); end
      end
    end
    total++;
    if (bursts < 4) begin bad++; $display("FAIL rand_bursts: got %0d, need >=4", bursts); end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset();
    for (int i = 0; i < N; i++) cyc(1, 0);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      cyc(0, 0);
      if (bus.in_valid && run == 10) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mid_reach: burst cycle 10 got %0d, need 1", found); end
    rst_n = 0;
    #1;
    total += 2;
    if (bus.in_valid !== 1'b0) begin bad++; $display("FAIL mid_in_valid: got %b, need 0", bus.in_valid); end
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL mid_s_ready: got %b, need 0", bus.s_ready); end
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < N; i++) cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    total += 3;
    if (bus.in_valid !== 1'b1) begin bad++; $display("FAIL after_rst_start: got %b, need 1", bus.in_valid); end
    if (start_cyc != frame_done_cyc + 2) begin
      bad++; $display("FAIL after_rst_cyc: got %0d, need %0d", start_cyc, frame_done_cyc + 2);
    end
    if (bus.din_r !== 12'sd0) begin bad++; $display("FAIL after_rst_idx0: got %0d, need 0", bus.din_r); end
    for (int i = 0; i < 36; i++) cyc(0, 0);
  endtask

  task automatic test_err();
    apply_reset();
    for (int i = 0; i < N - 1; i++) cyc(0, 1);
    cyc(0, 0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %b, need 0", err); end
    cyc(0, 1);
    cyc(0, 0);
    total += 2;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b, need 1", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL err_busy: got %b, need 0", busy); end
    repeat (3) cyc(0, 0);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b, need 1", err); end
  endtask

  task automatic test_gap3();
    logic [2*W-1:0] d3[$];
    logic [2*W-1:0] v;
    int runs[$];
    int n, len;
    bit cur;
    apply_reset();
    n = 0; len = 0; cur = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus3.in_valid) begin
        total++;
        if (d3.size() == 0) begin
          bad++; $display("FAIL gap3_data: got %h, no sample expected", {bus3.din_r, bus3.din_i});
        end else begin
          v = d3.pop_front();
          if ({bus3.din_r, bus3.din_i} !== v) begin
            bad++; $display("FAIL gap3_data: got %h, need %h", {bus3.din_r, bus3.din_i}, v);
          end
        end
      end
      if (bus3.in_valid === cur) len++;
      else begin
        if (cur || runs.size() > 0) runs.push_back(len);
        cur = bus3.in_valid; len = 1;
      end
      v = (2*W)'($urandom);
      bus3.s_valid = (n < 2 * N);
      {bus3.s_r, bus3.s_i} = v;
      if (bus3.s_valid && bus3.s_ready) begin d3.push_back(v); n++; end
    end
    bus3.s_valid = 0;
    total += 4;
    if (n != 2 * N) begin bad++; $display("FAIL gap3_accepts: got %0d, need %0d", n, 2 * N); end
    if (runs.size() < 3) begin
      bad++; $display("FAIL gap3_runs: got %0d runs, need >=3", runs.size());
    end else begin
      if (runs[0] != N) begin bad++; $display("FAIL gap3_burst1: got %0d, need %0d", runs[0], N); end
      if (runs[1] != GAP3) begin bad++; $display("FAIL gap3_idle: got %0d, need %0d", runs[1], GAP3); end
      if (runs[2] != N) begin bad++; $display("FAIL gap3_burst2: got %0d, need %0d", runs[2], N); end
    end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    cyc_n = 0;
    test_reset();
    test_first_frame();
    test_credit();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_err();
    test_gap3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, need bench completion");
    $fatal(1);
  end
endmodule
